matrix_mul_engine: RTL

//  Parametrised NxN matrix multiplier C = A x B with an output-stationary array of N*N MACs.

---
 rtl/matrix_mul_engine.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/matrix_mul_engine.sv
// NxN output-stationary matrix multiplier C = A x B: element-wise operand load,
// start/busy/done control and a row-major valid/ready result stream.
module matrix_mul_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 3,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N),
  parameter int SIGNED     = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [$clog2(N)-1:0]  wr_row,
  input  logic [$clog2(N)-1:0]  wr_col,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic [$clog2(N)-1:0]  res_row,
  output logic [$clog2(N)-1:0]  res_col,
  output logic                  res_last
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST  = IW'(N - 1);
  localparam logic [IW:0]   N_EXT = (IW + 1)'(N);

  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN} state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] mat_a [N][N];
  logic [DATA_WIDTH-1:0] mat_b [N][N];
  logic [ACC_WIDTH-1:0]  acc   [N][N];
  logic [IW-1:0]         k, out_row, out_col;
  logic                  done_q;
  logic                  xfer;
  logic                  wr_ok;

  // Full 2*DATA_WIDTH product, extended to the accumulator according to operand signedness.
  function automatic logic [ACC_WIDTH-1:0] ext_product(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
    logic signed [2*DATA_WIDTH-1:0] prod_s;
    logic        [2*DATA_WIDTH-1:0] prod_u;
    prod_s = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) *
             $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
    prod_u = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
    if (SIGNED != 0) return ACC_WIDTH'(prod_s);
    return ACC_WIDTH'(prod_u);
  endfunction

  assign xfer  = res_valid & res_ready;
  assign wr_ok = wr_en && (state == IDLE) &&
                 ({1'b0, wr_row} < N_EXT) && ({1'b0, wr_col} < N_EXT);
  assign done  = done_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = COMPUTE;
      COMPUTE: if (k == LAST) state_nx = DRAIN;
      DRAIN:   if (xfer && res_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    res_valid = (state == DRAIN);
    res_last  = (state == DRAIN) && (out_row == LAST) && (out_col == LAST);
    res_data  = (state == DRAIN) ? acc[out_row][out_col] : '0;
    res_row   = out_row;
    res_col   = out_col;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      k       <= '0;
      out_row <= '0;
      out_col <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == DRAIN) && xfer && res_last;
      case (state)
        IDLE: k <= '0;
        COMPUTE: begin
          if (k == LAST) begin
            k       <= '0;
            out_row <= '0;
            out_col <= '0;
          end else begin
            k <= k + IW'(1);
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (out_col == LAST) begin
              out_col <= '0;
              out_row <= (out_row == LAST) ? '0 : out_row + IW'(1);
            end else begin
              out_col <= out_col + IW'(1);
            end
          end
        end
        default: k <= '0;
      endcase
    end
  end

  // Operand store: writable only while idle, frozen for the duration of a job.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int m = 0; m < N; m++)
        for (int n = 0; n < N; n++) begin
          mat_a[m][n] <= '0;
          mat_b[m][n] <= '0;
        end
    end else if (wr_ok) begin
      if (wr_sel) mat_b[wr_row][wr_col] <= wr_data;
      else        mat_a[wr_row][wr_col] <= wr_data;
    end
  end

  // MAC array: one rank-1 update per COMPUTE cycle, restarting the sum at k==0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int m = 0; m < N; m++)
        for (int n = 0; n < N; n++)
          acc[m][n] <= '0;
    end else if (state == COMPUTE) begin
      for (int m = 0; m < N; m++)
        for (int n = 0; n < N; n++)
          acc[m][n] <= ((k == '0) ? '0 : acc[m][n]) + ext_product(mat_a[m][k], mat_b[k][n]);
    end
  end

endmodule
